id_decode_pipe: RTL and testbench

Parametrised decode stage with an integrated ID/EX pipeline register. It decodes RV32I instructions from IF/ID and reads a configurable-depth register file with write-through bypass from WB. It also detects load-use hazards, injects bubbles automatically, and presents a registered decode bundle to EX over a valid/ready handshake with flush support. It sits between the IF/ID register and the EX stage and replaces the purely combinational decode path.

---
 rtl/id_decode_pipe_if.sv | 45 ++++
 rtl/id_decode_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_id_decode_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_decode_pipe_if.sv
// Bundle of IF/ID, WB-bypass and ID/EX handshake signals around the decode stage.
// slave is the decode stage's view, master is the surrounding pipeline's view.
interface id_decode_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            wb_regwrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [XLEN-1:0] out_branch_target;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic            out_funct7_5;
  logic [6:0]      out_opcode;
  logic [9:0]      out_ctrl;
  logic            out_illegal;
  logic [31:0]     stall_count;

  modport master (
    output in_valid, in_pc, in_instr, wb_regwrite, wb_rd, wb_wdata, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_plus4, out_branch_target, out_imm,
           out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd, out_funct3,
           out_funct7_5, out_opcode, out_ctrl, out_illegal, stall_count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, wb_regwrite, wb_rd, wb_wdata, flush, out_ready,
    output in_ready, out_valid, out_pc, out_pc_plus4, out_branch_target, out_imm,
           out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd, out_funct3,
           out_funct7_5, out_opcode, out_ctrl, out_illegal, stall_count
  );
endinterface

// File: rtl/id_decode_pipe.sv
// RV32I decode stage: register file with WB bypass, load-use bubble insertion and
// a registered ID/EX bundle. Both sides are valid/ready: a transfer happens on a
// rising edge where valid & ready are both 1; valid never waits on ready.
module id_decode_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input logic             clk,
  input logic             reset,
  id_decode_pipe_if.slave bus
);
  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       jump;
    logic       wb_sel;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [6:0]      opcode;
    ctrl_t           ctrl;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            r_valid;
  bundle_t         r_bundle;
  logic [31:0]     r_stall;

  logic [31:0]     w_i;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs [2];
  logic [XLEN-1:0] w_rs_val [2];
  logic [31:0]     w_imm32;
  ctrl_t           w_ctrl;
  logic            w_illegal;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  bundle_t         w_bundle;
  logic            w_adv;
  logic            w_haz;
  logic            w_wb_ok;

  assign w_i      = bus.in_instr;
  assign w_opcode = w_i[6:0];
  assign w_rs[0]  = w_i[19:15];
  assign w_rs[1]  = w_i[24:20];
  // RV32E has no x16..x31: such writes are dropped and such reads return 0.
  assign w_wb_ok  = bus.wb_regwrite && (bus.wb_rd != 5'd0) &&
                    ((NUM_REGS == 32) || !bus.wb_rd[4]);

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_rs_val[k] = '0;
      if (w_rs[k] != 5'd0 && ((NUM_REGS == 32) || !w_rs[k][4])) begin
        if (w_wb_ok && bus.wb_rd == w_rs[k]) w_rs_val[k] = bus.wb_wdata;
        else                                  w_rs_val[k] = r_regs[w_rs[k][RA_W-1:0]];
      end
    end
  end

  always_comb begin
    w_ctrl     = '0;
    w_illegal  = 1'b0;
    w_imm32    = '0;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_ctrl.regwrite = 1'b1; w_ctrl.aluop = 2'b10; w_uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        w_ctrl.alusrc = 1'b1; w_ctrl.regwrite = 1'b1; w_ctrl.aluop = 2'b10;
        w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
      end
      OP_LOAD: begin
        w_ctrl.alusrc = 1'b1; w_ctrl.memtoreg = 1'b1; w_ctrl.regwrite = 1'b1;
        w_ctrl.memread = 1'b1;
        w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
      end
      OP_STORE: begin
        w_ctrl.alusrc = 1'b1; w_ctrl.memwrite = 1'b1; w_uses_rs2 = 1'b1;
        w_imm32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
      end
      OP_BRANCH: begin
        w_ctrl.branch = 1'b1; w_ctrl.aluop = 2'b01; w_uses_rs2 = 1'b1;
        w_imm32 = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
      end
      OP_JAL: begin
        w_ctrl.regwrite = 1'b1; w_ctrl.jump = 1'b1; w_ctrl.wb_sel = 1'b1; w_uses_rs1 = 1'b0;
        w_imm32 = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      end
      OP_JALR: begin
        w_ctrl.alusrc = 1'b1; w_ctrl.regwrite = 1'b1; w_ctrl.jump = 1'b1; w_ctrl.wb_sel = 1'b1;
        w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
      end
      OP_LUI: begin
        w_ctrl.alusrc = 1'b1; w_ctrl.regwrite = 1'b1; w_ctrl.aluop = 2'b11; w_uses_rs1 = 1'b0;
        w_imm32 = {w_i[31:12], 12'b0};
      end
      OP_AUIPC: begin
        w_ctrl.alusrc = 1'b1; w_ctrl.regwrite = 1'b1; w_uses_rs1 = 1'b0;
        w_imm32 = {w_i[31:12], 12'b0};
      end
      OP_FENCE, OP_SYSTEM: w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_bundle               = '0;
    w_bundle.pc            = bus.in_pc;
    w_bundle.pc_plus4      = bus.in_pc + XLEN'(4);
    w_bundle.imm           = XLEN'($signed(w_imm32));
    w_bundle.branch_target = bus.in_pc + XLEN'($signed(w_imm32));
    w_bundle.rs1_val       = w_rs_val[0];
    w_bundle.rs2_val       = w_rs_val[1];
    w_bundle.rs1           = w_rs[0];
    w_bundle.rs2           = w_rs[1];
    w_bundle.rd            = w_i[11:7];
    w_bundle.funct3        = w_i[14:12];
    w_bundle.funct7_5      = w_i[30];
    w_bundle.opcode        = w_opcode;
    w_bundle.ctrl          = w_ctrl;
    w_bundle.illegal       = w_illegal;
  end

  assign w_adv = !r_valid || bus.out_ready;
  assign w_haz = bus.in_valid && r_valid && r_bundle.ctrl.memread && (r_bundle.rd != 5'd0) &&
                 ((w_uses_rs1 && w_rs[0] == r_bundle.rd) || (w_uses_rs2 && w_rs[1] == r_bundle.rd));
  assign bus.in_ready = bus.flush || (w_adv && !w_haz);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else if (w_wb_ok) begin
      r_regs[bus.wb_rd[RA_W-1:0]] <= bus.wb_wdata;
    end
  end

  // A bubble zeroes the bundle, which also clears memread so the stalled
  // instruction is accepted on the following advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
      r_stall  <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_adv && w_haz) begin
      r_valid  <= 1'b1;
      r_bundle <= '0;
      if (r_stall != '1) r_stall <= r_stall + 32'd1;
    end else if (w_adv && bus.in_valid) begin
      r_valid  <= 1'b1;
      r_bundle <= w_bundle;
    end else if (w_adv) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid         = r_valid;
  assign bus.out_pc            = r_bundle.pc;
  assign bus.out_pc_plus4      = r_bundle.pc_plus4;
  assign bus.out_branch_target = r_bundle.branch_target;
  assign bus.out_imm           = r_bundle.imm;
  assign bus.out_rs1_val       = r_bundle.rs1_val;
  assign bus.out_rs2_val       = r_bundle.rs2_val;
  assign bus.out_rs1           = r_bundle.rs1;
  assign bus.out_rs2           = r_bundle.rs2;
  assign bus.out_rd            = r_bundle.rd;
  assign bus.out_funct3        = r_bundle.funct3;
  assign bus.out_funct7_5      = r_bundle.funct7_5;
  assign bus.out_opcode        = r_bundle.opcode;
  assign bus.out_ctrl          = r_bundle.ctrl;
  assign bus.out_illegal       = r_bundle.illegal;
  assign bus.stall_count       = r_stall;
endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: a 32-register and a 16-register (RV32E) build
// driven with hand-encoded instructions and hand-computed expectations.
module tb_id_decode_pipe;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_decode_pipe_if #(.XLEN(32)) bus ();
  id_decode_pipe_if #(.XLEN(32)) bus16 ();

  id_decode_pipe #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  id_decode_pipe #(.XLEN(32), .NUM_REGS(16)) dut16 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus16)
  );

  // out_ctrl bit positions: alusrc=9 memtoreg=8 regwrite=7 memread=6 memwrite=5
  // branch=4 aluop=3:2 jump=1 wb_sel=0
  localparam int C_ALUSRC   = 9;
  localparam int C_REGWRITE = 7;
  localparam int C_MEMREAD  = 6;
  localparam int C_BRANCH   = 4;

  localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093;
  localparam logic [31:0] I_LW_X5_X2    = 32'h0001_2283;
  localparam logic [31:0] I_ADD_X6_X5X1 = 32'h0012_8333;
  localparam logic [31:0] I_LUI_X5      = 32'h1234_52B7;
  localparam logic [31:0] I_ADD_X4_X3X3 = 32'h0031_8233;
  localparam logic [31:0] I_ADD_X9_X3X0 = 32'h0001_84B3;
  localparam logic [31:0] I_ADD_X8_X0X0 = 32'h0000_0433;
  localparam logic [31:0] I_BEQ_M8      = 32'hFE00_0CE3;
  localparam logic [31:0] I_ADD_X7_X20  = 32'h000A_03B3;
  localparam logic [31:0] I_ILLEGAL     = 32'h0000_007F;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = instr;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_regwrite = we;
    bus.wb_rd       = rd;
    bus.wb_wdata    = data;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_pc     = 32'h0;
    bus16.in_instr  = 32'h0;
    bus16.wb_regwrite = 1'b0;
    bus16.wb_rd     = 5'd0;
    bus16.wb_wdata  = 32'h0;
    bus16.flush     = 1'b0;
    bus16.out_ready = 1'b1;

    tick(); tick();
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_stall_count", 64'(bus.stall_count), 64'd0);
    chk("reset_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    reset = 1'b1;

    // ADDI x1,x0,5 at 0x100
    drive(1'b1, 32'h100, I_ADDI_X1_5);
    #1;
    chk("addi_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("addi_out_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_imm", 64'(bus.out_imm), 64'd5);
    chk("addi_pc_plus4", 64'(bus.out_pc_plus4), 64'h104);
    chk("addi_regwrite", 64'(bus.out_ctrl[C_REGWRITE]), 64'd1);
    chk("addi_alusrc", 64'(bus.out_ctrl[C_ALUSRC]), 64'd1);
    chk("addi_rd", 64'(bus.out_rd), 64'd1);

    // LW x5,0(x2) then ADD x6,x5,x1: one bubble
    drive(1'b1, 32'h104, I_LW_X5_X2);
    tick();
    chk("lw_memread", 64'(bus.out_ctrl[C_MEMREAD]), 64'd1);
    chk("lw_rd", 64'(bus.out_rd), 64'd5);
    drive(1'b1, 32'h108, I_ADD_X6_X5X1);
    #1;
    chk("haz_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("bubble_valid", 64'(bus.out_valid), 64'd1);
    chk("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("bubble_pc", 64'(bus.out_pc), 64'd0);
    chk("bubble_stall_count", 64'(bus.stall_count), 64'd1);
    chk("after_bubble_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("add_opcode", 64'(bus.out_opcode), 64'h33);
    chk("add_rd", 64'(bus.out_rd), 64'd6);
    chk("add_pc", 64'(bus.out_pc), 64'h108);

    // LW x5 then LUI x5: no hazard
    drive(1'b1, 32'h10C, I_LW_X5_X2);
    tick();
    drive(1'b1, 32'h110, I_LUI_X5);
    #1;
    chk("lui_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("lui_opcode", 64'(bus.out_opcode), 64'h37);
    chk("lui_imm", 64'(bus.out_imm), 64'h1234_5000);
    chk("lui_stall_count", 64'(bus.stall_count), 64'd1);

    // WB bypass in the accept cycle, then read back from storage
    drive(1'b1, 32'h114, I_ADD_X4_X3X3);
    wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    tick();
    chk("bypass_rs1", 64'(bus.out_rs1_val), 64'hDEAD_BEEF);
    chk("bypass_rs2", 64'(bus.out_rs2_val), 64'hDEAD_BEEF);
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h118, I_ADD_X9_X3X0);
    tick();
    chk("stored_rs1", 64'(bus.out_rs1_val), 64'hDEAD_BEEF);
    chk("stored_rs2_x0", 64'(bus.out_rs2_val), 64'd0);

    // Write to x0 must be ignored, including by the bypass
    drive(1'b1, 32'h11C, I_ADD_X8_X0X0);
    wb(1'b1, 5'd0, 32'h55);
    tick();
    chk("x0_rs1", 64'(bus.out_rs1_val), 64'd0);
    wb(1'b0, 5'd0, 32'h0);

    // BEQ x0,x0,-8 at 0x200 then 3 cycles of backpressure, then flush
    drive(1'b1, 32'h200, I_BEQ_M8);
    tick();
    chk("beq_target", 64'(bus.out_branch_target), 64'h1F8);
    chk("beq_imm", 64'(bus.out_imm), 64'hFFFF_FFF8);
    chk("beq_branch", 64'(bus.out_ctrl[C_BRANCH]), 64'd1);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h204, I_ADDI_X1_5);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_pc", 64'(bus.out_pc), 64'h200);
      chk("bp_target", 64'(bus.out_branch_target), 64'h1F8);
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("flush_dropped", 64'(bus.out_valid), 64'd0);

    // Illegal opcode 0x7F
    drive(1'b1, 32'h300, I_ILLEGAL);
    tick();
    chk("ill_valid", 64'(bus.out_valid), 64'd1);
    chk("ill_flag", 64'(bus.out_illegal), 64'd1);
    chk("ill_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("ill_pc", 64'(bus.out_pc), 64'h300);

    // RV32E build: x20 does not exist; x3 does
    bus16.in_valid    = 1'b1;
    bus16.in_pc       = 32'h400;
    bus16.in_instr    = I_ADD_X7_X20;
    bus16.wb_regwrite = 1'b1;
    bus16.wb_rd       = 5'd20;
    bus16.wb_wdata    = 32'h1234;
    drive(1'b1, 32'h400, I_ADD_X7_X20);
    wb(1'b1, 5'd20, 32'h1234);
    tick();
    chk("e_x20_bypass", 64'(bus16.out_rs1_val), 64'd0);
    chk("i_x20_bypass", 64'(bus.out_rs1_val), 64'h1234);
    bus16.wb_rd    = 5'd3;
    bus16.wb_wdata = 32'hABCD;
    tick();
    chk("e_x20_stored", 64'(bus16.out_rs1_val), 64'd0);
    chk("i_x20_stored", 64'(bus.out_rs1_val), 64'h1234);
    bus16.wb_regwrite = 1'b0;
    bus16.in_instr    = I_ADD_X9_X3X0;
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("e_x3_stored", 64'(bus16.out_rs1_val), 64'hABCD);
    bus16.in_valid = 1'b0;

    // Reset while a load-use stall is pending
    drive(1'b1, 32'h500, I_LW_X5_X2);
    tick();
    drive(1'b1, 32'h504, I_ADD_X6_X5X1);
    #1;
    chk("rst_haz_in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_stall", 64'(bus.stall_count), 64'd0);
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("rst_post_valid", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 32'h508, I_ADD_X9_X3X0);
    tick();
    chk("rst_regfile_cleared", 64'(bus.out_rs1_val), 64'd0);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
